// File: rtl/div_ctrl_pkg.sv
// Shared types and reset defaults for the clock-divider run-time controller.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned DEF_LIMIT = 750000;
    localparam int unsigned DEF_DUTY  = 250000;

endpackage

// File: rtl/div_cfg_ctrl_if.sv
// Control/config bundle between the top-level control logic and div_cfg_ctrl.
interface div_cfg_ctrl_if #(
    parameter int unsigned CNT_W   = 20,
    parameter int unsigned BURST_W = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_limit;
    logic [CNT_W-1:0]   cfg_duty;
    logic [BURST_W-1:0] cfg_burst;
    logic               cfg_err;
    logic               start;
    logic               stop;
    logic               busy;
    logic               clk_out;
    logic               period_done;

    modport master (
        output cfg_valid, cfg_limit, cfg_duty, cfg_burst, start, stop,
        input  cfg_ready, cfg_err, busy, clk_out, period_done
    );

    modport slave (
        input  cfg_valid, cfg_limit, cfg_duty, cfg_burst, start, stop,
        output cfg_ready, cfg_err, busy, clk_out, period_done
    );
endinterface

// File: rtl/div_core.sv
// Divider counter with wrap detect and registered duty compare.
module div_core #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic             clk_out_o,
    output logic             wrap_o
);
    logic [CNT_W-1:0] count_q, count_d;
    logic             clk_q, clk_d;

    assign wrap_o    = en_i && (count_q == limit_i);
    assign clk_out_o = clk_q;

    // clr_i holds the counter and output low whenever this or the next cycle is idle.
    always_comb begin
        count_d = count_q + 1'b1;
        clk_d   = (count_q < duty_i);
        if (clr_i) begin
            count_d = '0;
            clk_d   = 1'b0;
        end else if (wrap_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            clk_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            clk_q   <= clk_d;
        end
    end
endmodule

// File: rtl/div_cfg_ctrl.sv
// Run-time controller: FSM, config validation, shadow registers and burst counter.
// Optional DIVCTRL_HARD_STOP_EN: stop in RUN aborts at once instead of draining.
module div_cfg_ctrl #(
    parameter int unsigned      CNT_W     = 20,
    parameter int unsigned      BURST_W   = 8,
    parameter logic [CNT_W-1:0] DEF_LIMIT = CNT_W'(div_ctrl_pkg::DEF_LIMIT),
    parameter logic [CNT_W-1:0] DEF_DUTY  = CNT_W'(div_ctrl_pkg::DEF_DUTY)
) (
    input  logic         clk_in,
    input  logic         rst,
    div_cfg_ctrl_if.slave bus
);
    import div_ctrl_pkg::*;

`ifdef DIVCTRL_HARD_STOP_EN
    localparam bit HARD_STOP = 1'b1;
`else
    localparam bit HARD_STOP = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   lim_q, lim_d, duty_q, duty_d;
    logic [CNT_W-1:0]   sh_lim_q, sh_lim_d, sh_duty_q, sh_duty_d;
    logic               pend_q, pend_d;
    logic [BURST_W-1:0] bcfg_q, bcfg_d, bleft_q, bleft_d;
    logic               err_q, err_d;

    logic               wrap, abort, accept, cfg_ok, core_clr;
    logic [CNT_W:0]     lim_p1;

    assign lim_p1 = {1'b0, bus.cfg_limit} + 1'b1;
    assign cfg_ok = (bus.cfg_limit != '0) && ({1'b0, bus.cfg_duty} <= lim_p1);
    assign accept = bus.cfg_valid && !pend_q;
    assign abort  = HARD_STOP && (state_q == RUN) && bus.stop;

    always_comb begin
        state_d   = state_q;
        lim_d     = lim_q;
        duty_d    = duty_q;
        sh_lim_d  = sh_lim_q;
        sh_duty_d = sh_duty_q;
        pend_d    = pend_q;
        bcfg_d    = bcfg_q;
        bleft_d   = bleft_q;
        err_d     = accept && !cfg_ok;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    bleft_d = bcfg_q;
                end
            end
            RUN: begin
                if (wrap && bleft_q != '0) bleft_d = bleft_q - 1'b1;
                if (abort)                                  state_d = IDLE;
                else if (bus.stop)                          state_d = wrap ? IDLE : DRAIN;
                else if (wrap && bleft_q == BURST_W'(1))    state_d = IDLE;
            end
            DRAIN: begin
                if (wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A shadow left over from the final wrap of a run is flushed once idle.
        if (pend_q && (wrap || state_q == IDLE)) begin
            lim_d  = sh_lim_q;
            duty_d = sh_duty_q;
            pend_d = 1'b0;
        end
        if (abort) pend_d = 1'b0;

        if (accept && cfg_ok) begin
            bcfg_d = bus.cfg_burst;
            if (state_q == IDLE) begin
                lim_d  = bus.cfg_limit;
                duty_d = bus.cfg_duty;
            end else begin
                sh_lim_d  = bus.cfg_limit;
                sh_duty_d = bus.cfg_duty;
                pend_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lim_q     <= DEF_LIMIT;
            duty_q    <= DEF_DUTY;
            sh_lim_q  <= '0;
            sh_duty_q <= '0;
            pend_q    <= 1'b0;
            bcfg_q    <= '0;
            bleft_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lim_q     <= lim_d;
            duty_q    <= duty_d;
            sh_lim_q  <= sh_lim_d;
            sh_duty_q <= sh_duty_d;
            pend_q    <= pend_d;
            bcfg_q    <= bcfg_d;
            bleft_q   <= bleft_d;
            err_q     <= err_d;
        end
    end

    // Clearing on entry as well as exit makes every run start at count 0.
    assign core_clr = (state_q == IDLE) || (state_d == IDLE);

    div_core #(.CNT_W(CNT_W)) u_core (
        .clk_in    (clk_in),
        .rst       (rst),
        .en_i      (state_q != IDLE),
        .clr_i     (core_clr),
        .limit_i   (lim_q),
        .duty_i    (duty_q),
        .clk_out_o (bus.clk_out),
        .wrap_o    (wrap)
    );

    assign bus.period_done = wrap && !abort;
    assign bus.busy        = (state_q != IDLE);
    assign bus.cfg_ready   = !pend_q;
    assign bus.cfg_err     = err_q;
endmodule

// File: tb/tb_div_cfg_ctrl.sv
// Bench for div_cfg_ctrl: config table, directed corner sequences and random run vs reference model.
module tb_div_cfg_ctrl;
    localparam int CW = 8;
    localparam int BW = 4;
    localparam logic [7:0] DL = 8'd9;
    localparam logic [7:0] DD = 8'd3;
`ifdef DIVCTRL_HARD_STOP_EN
    localparam bit HARD = 1'b1;
`else
    localparam bit HARD = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    always #5 clk_in = ~clk_in;

    div_cfg_ctrl_if #(.CNT_W(CW), .BURST_W(BW)) bus ();

    div_cfg_ctrl #(.CNT_W(CW), .BURST_W(BW), .DEF_LIMIT(DL), .DEF_DUTY(DD)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] lim;
        logic [7:0] duty;
        logic [3:0] burst;
        bit         err;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: mode (0 idle, 1 run, 2 drain), position in period, settings.
    int m_st, m_pos, m_lim, m_duty, m_slim, m_sduty, m_bcfg, m_bleft;
    bit m_pend, m_err, m_clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pos = 0; m_lim = DL; m_duty = DD;
        m_slim = 0; m_sduty = 0; m_pend = 0; m_bcfg = 0; m_bleft = 0;
        m_err = 0; m_clk = 0;
    endtask

    task automatic model_step();
        bit acc, ok, wrap, abort;
        int nst, l, d;
        l     = int'(bus.cfg_limit);
        d     = int'(bus.cfg_duty);
        acc   = bus.cfg_valid && !m_pend;
        ok    = (l >= 1) && (d <= l + 1);
        wrap  = (m_st != 0) && (m_pos == m_lim);
        abort = HARD && (m_st == 1) && bus.stop;
        nst   = m_st;
        if (m_st == 0 && bus.start) nst = 1;
        else if (m_st == 1) begin
            if (abort) nst = 0;
            else if (bus.stop) nst = wrap ? 0 : 2;
            else if (wrap && m_bleft == 1) nst = 0;
        end else if (m_st == 2 && wrap) nst = 0;

        // Output reflects the previous cycle's position only while running on both sides.
        m_clk = (m_st != 0 && nst != 0) ? (m_pos < m_duty) : 1'b0;
        m_pos = (m_st == 0 || nst == 0 || wrap) ? 0 : m_pos + 1;

        if (m_st == 0 && bus.start) m_bleft = m_bcfg;
        else if (m_st == 1 && wrap && m_bleft > 0) m_bleft--;

        if (m_pend && (wrap || m_st == 0)) begin
            m_lim = m_slim; m_duty = m_sduty; m_pend = 0;
        end
        if (abort) m_pend = 0;
        if (acc && ok) begin
            m_bcfg = int'(bus.cfg_burst);
            if (m_st == 0) begin m_lim = l; m_duty = d; end
            else begin m_slim = l; m_sduty = d; m_pend = 1; end
        end
        m_err = acc && !ok;
        m_st  = nst;
    endtask

    task automatic check_outputs();
        chk("busy", bus.busy, m_st != 0);
        chk("cfg_ready", bus.cfg_ready, !m_pend);
        chk("clk_out", bus.clk_out, m_clk);
        chk("cfg_err", bus.cfg_err, m_err);
        chk("period_done", bus.period_done,
            (m_st != 0) && (m_pos == m_lim) && !(HARD && m_st == 1 && bus.stop));
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk_in);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic send_cfg(input int l, input int d, input int b);
        bus.cfg_limit = 8'(l);
        bus.cfg_duty  = 8'(d);
        bus.cfg_burst = 4'(b);
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_pd(input int maxc, input string nm);
        int k;
        k = 0;
        while (bus.period_done !== 1'b1 && k < maxc) begin
            tick();
            k++;
        end
        chk(nm, bus.period_done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [8];
        bit   exp2 [6];
        int   n;

        tbl[0] = '{8'd3,   8'd1,   4'd0, 1'b0};
        tbl[1] = '{8'd0,   8'd0,   4'd0, 1'b1};
        tbl[2] = '{8'd1,   8'd2,   4'd0, 1'b0};
        tbl[3] = '{8'd1,   8'd3,   4'd0, 1'b1};
        tbl[4] = '{8'd4,   8'd6,   4'd0, 1'b1};
        tbl[5] = '{8'd4,   8'd5,   4'd0, 1'b0};
        tbl[6] = '{8'd255, 8'd255, 4'd0, 1'b0};
        tbl[7] = '{8'd255, 8'd0,   4'd2, 1'b0};
        exp2   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        bus.cfg_valid = 1'b0; bus.cfg_limit = '0; bus.cfg_duty = '0;
        bus.cfg_burst = '0;   bus.start = 1'b0;   bus.stop = 1'b0;
        model_reset();

        // Reset state
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.cfg_ready, 1);
        chk("rst_clk", bus.clk_out, 0);
        chk("rst_err", bus.cfg_err, 0);
        chk("rst_pd", bus.period_done, 0);
        repeat (2) @(posedge clk_in);
        #1;
        rst = 1'b0;
        tick();

        // Validation table, applied in IDLE
        for (int i = 0; i < 8; i++) begin
            send_cfg(tbl[i].lim, tbl[i].duty, tbl[i].burst);
            chk("tbl_err", bus.cfg_err, tbl[i].err);
            chk("tbl_ready", bus.cfg_ready, 1);
            tick();
        end

        // Continuous run, limit 3 duty 1
        send_cfg(3, 1, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            chk("t1_clk", bus.clk_out, (c % 4) == 1);
            chk("t1_pd", bus.period_done, (c % 4) == 3);
            chk("t1_busy", bus.busy, 1);
            tick();
        end

        // Mid-period reconfig to limit 4 duty 2
        tick();
        send_cfg(4, 2, 0);
        chk("t2_ready_lo", bus.cfg_ready, 0);
        tick();
        chk("t2_ready_lo2", bus.cfg_ready, 0);
        chk("t2_wrap", bus.period_done, 1);
        tick();
        chk("t2_ready_hi", bus.cfg_ready, 1);
        for (int c = 0; c < 6; c++) begin
            chk("t2_clk", bus.clk_out, exp2[c]);
            chk("t2_pd", bus.period_done, c == 4);
            tick();
        end

        // Rejected config leaves waveform alone
        send_cfg(4, 6, 0);
        chk("t3_err", bus.cfg_err, 1);
        chk("t3_ready", bus.cfg_ready, 1);
        tick();
        chk("t3_err_clr", bus.cfg_err, 0);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.period_done === 1'b1) n++;
            tick();
        end
        chk("t3_pds", n, 2);

        // Stop at count 1 with limit 3
        send_cfg(3, 1, 0);
        wait_pd(20, "t5_wait");
        tick();
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        if (HARD) begin
            chk("t5_hard_busy", bus.busy, 0);
            chk("t5_hard_clk", bus.clk_out, 0);
        end
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.period_done === 1'b1) n++;
            tick();
        end
        chk("t5_pds", n, HARD ? 0 : 1);
        chk("t5_idle", bus.busy, 0);

        // Burst of 3 periods
        send_cfg(1, 1, 3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.period_done === 1'b1) n++;
            tick();
        end
        chk("t4_pds", n, 3);
        chk("t4_busy", bus.busy, 0);
        chk("t4_clk", bus.clk_out, 0);

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            bus.cfg_valid = ($urandom_range(0, 3) == 0);
            bus.cfg_limit = 8'($urandom_range(0, 7));
            bus.cfg_duty  = 8'($urandom_range(0, 9));
            bus.cfg_burst = 4'($urandom_range(0, 3));
            bus.start     = ($urandom_range(0, 5) == 0);
            bus.stop      = ($urandom_range(0, 11) == 0);
            tick();
        end
        bus.cfg_valid = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        tick();

        // Asynchronous reset mid-run
        send_cfg(3, 1, 0);
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t6_busy", bus.busy, 0);
        chk("t6_ready", bus.cfg_ready, 1);
        chk("t6_clk", bus.clk_out, 0);
        chk("t6_err", bus.cfg_err, 0);
        chk("t6_pd", bus.period_done, 0);
        model_reset();
        tick();
        rst = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_pd(30, "t6_wait");
        tick();
        n = 1;
        while (bus.period_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t6_period", n, int'(DL) + 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
